// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Holds frame width, FSM state encoding and parity mode.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    typedef enum logic {
        PAR_EVEN,
        PAR_ODD
    } parity_mode_t;

    localparam parity_mode_t PARITY_MODE = PAR_EVEN;

    // Parity bit a well-formed frame carries for data d under mode m.
    function automatic logic parity_bit(
        input logic [DATA_BITS-1:0] d,
        input parity_mode_t         m
    );
        return (^d) ^ (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous input pins.
// RST_VAL sets the level both flops take during reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Bytes are delivered with a one-cycle valid strobe; bad stop bits strobe frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int BIT_TICKS = CLOCK_RATE / BAUD_RATE;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CNT_W     = $clog2(BIT_TICKS) + 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_TICKS - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 w_rxs;
    logic                 w_sample;
    logic                 w_shift;
    logic                 w_done;
    logic                 w_ferr;
    logic                 w_par_smp;
    logic                 w_half;
    logic                 w_bit;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    assign w_half = (r_baud_cnt == HALF_M1);
    assign w_bit  = (r_baud_cnt == BIT_M1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        w_par_smp   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_half) begin
                    w_sample    = 1'b1;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit) begin
                    w_sample = 1'b1;
                    w_shift  = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit) begin
                    w_sample    = 1'b1;
                    w_par_smp   = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit) begin
                    w_sample = 1'b1;
                    if (w_rxs) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit timing, shift register, delivered byte and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= w_done;
            r_ferr  <= w_ferr;
            if (w_state_nxt != r_state || w_sample ||
                r_state == ST_IDLE || r_state == ST_BREAK) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end
            if (r_state != ST_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_shift) begin
                r_shift[r_bit_cnt[2:0]] <= w_rxs;
            end
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_perr;

    // Parity check; a mismatch is reported alongside the delivered byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_par_smp) begin
                r_par_bad <= (w_rxs != parity_bit(r_shift, PARITY_MODE));
            end
            r_perr <= w_done & r_par_bad;
        end
    end

    assign parity_err = r_perr;
`endif

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BIT_TICKS=10, HALF=5.
// Expected frames are queued as they are sent and matched against DUT strobes.
module tb_uart_rx;

    localparam int BT   = 10;
    localparam int HALF = 5;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    exp_t q[$];
    int   n_checks;
    int   n_fail;
    int   n_valid;
    int   n_ferr;

    uart_rx #(
        .CLOCK_RATE (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_good);
        exp_t e;
        e.is_err = !stop;
        e.data   = d;
        e.perr   = !par_good;
        q.push_back(e);
        drive(1'b0, BT);
        for (int i = 0; i < 8; i++) drive(d[i], BT);
`ifdef UART_RX_PARITY_EN
        drive(par_good ? ^d : ~(^d), BT);
`endif
        drive(stop, BT);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (valid) n_valid++;
        if (frame_err) n_ferr++;
        if (valid || frame_err) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {valid, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind", {valid, frame_err},
                      e.is_err ? 2'b01 : 2'b10);
                if (!e.is_err) begin
                    check("data_out", data_out, e.data);
`ifdef UART_RX_PARITY_EN
                    check("parity_err", parity_err, e.perr);
`endif
                end
            end
        end
    end

    initial begin
        int v0;
        int f0;
        n_checks = 0;
        n_fail   = 0;
        n_valid  = 0;
        n_ferr   = 0;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 5);

        // Single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        drive(1'b1, 5);
        check("a5_busy_after", busy, 1'b0);
        check("a5_hold", data_out, 8'hA5);
        check("a5_valid_count", n_valid, 1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive(1'b1, 5);
        check("b2b_valid_count", n_valid, 3);
        check("b2b_last", data_out, 8'hFF);

        // 3-cycle glitch is a false start
        v0 = n_valid;
        f0 = n_ferr;
        drive(1'b0, 3);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_rise", busy, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, HALF + 4);
        check("glitch_busy_fall", busy, 1'b0);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Bad stop bit followed by a long break
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1);
        drive(1'b0, 30 * BT);
        check("break_busy_held", busy, 1'b1);
        check("break_one_ferr", n_ferr - f0, 1);
        check("break_no_valid", n_valid - v0, 0);
        check("break_data_kept", data_out, 8'hFF);
        drive(1'b1, 5);
        check("break_exit", busy, 1'b0);

        // Reset in the middle of data bit 4
        v0 = n_valid;
        drive(1'b1, 10);
        drive(1'b0, BT);
        for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, BT);
        drive(1'b1, 5);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", data_out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 3 * BT);
        check("rst_no_strobe", n_valid - v0, 0);
        send_frame(8'h12, 1'b1, 1'b1);
        drive(1'b1, 5);
        check("after_rst_valid", n_valid - v0, 1);
        check("after_rst_data", data_out, 8'h12);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: byte still delivered, flagged
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 5);
        check("par_data", data_out, 8'h07);
`endif

        // Drain: all queued frames must have produced strobes
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        check("drain_queue", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
